// File: rtl/data_sram_arbiter_pkg.sv
// Shared definitions for the data-side SRAM arbiter: transfer size
// encodings and the ids of the two masters sharing the slave port.
package data_sram_arbiter_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } sram_size_t;

  typedef enum logic {
    ID_CACHED   = 1'b0,
    ID_UNCACHED = 1'b1
  } master_id_t;

endpackage

// File: rtl/data_sram_arbiter_owner_fifo.sv
// In-order owner queue: records which master issued each accepted request
// so completions can be routed back. Push is refused when full and pop is
// ignored when empty, both judged on the registered count.
module data_sram_arbiter_owner_fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves
  // the count unchanged while both pointers advance.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while count says valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/data_sram_arbiter.sv
// Merges the cached (m0) and uncached (m1) data masters onto one SRAM-like
// slave port. Round-robin grant, held while the slave stalls a request, and
// an owner queue that steers each in-order completion back to its issuer.
module data_sram_arbiter
  import data_sram_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = 2,
  parameter int AW          = 32,
  parameter int DW          = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          m0_req,
  input  logic          m0_wr,
  input  logic [1:0]    m0_size,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_addr_ok,
  output logic          m0_data_ok,
  input  logic          m1_req,
  input  logic          m1_wr,
  input  logic [1:0]    m1_size,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_addr_ok,
  output logic          m1_data_ok,
  output logic          s_req,
  output logic          s_wr,
  output logic [1:0]    s_size,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  input  logic [DW-1:0] s_rdata,
  input  logic          s_addr_ok,
  input  logic          s_data_ok
);

  localparam int CW = $clog2(OUTSTANDING) + 1;

  logic          grant;
  logic          grant_req;
  logic          lock;
  logic          lock_id;
  logic          last_id;
  logic          accept;
  logic          stall;
  logic          fifo_full;
  logic          fifo_empty;
  logic          head_id;
  logic [CW-1:0] fifo_count;

  // Grant selection: a stalled request keeps its grant, otherwise ties go
  // to the master that was not accepted last.
  always_comb begin
    grant = ID_CACHED;
    if (lock) begin
      grant = lock_id;
    end else if (m0_req && m1_req) begin
      grant = ~last_id;
    end else if (m1_req) begin
      grant = ID_UNCACHED;
    end
  end

  assign grant_req = (grant == ID_UNCACHED) ? m1_req : m0_req;
  assign s_req     = grant_req && !fifo_full && resetn;
  assign accept    = s_req && s_addr_ok;
  assign stall     = s_req && !s_addr_ok;

  assign s_wr    = (grant == ID_UNCACHED) ? m1_wr    : m0_wr;
  assign s_size  = (grant == ID_UNCACHED) ? m1_size  : m0_size;
  assign s_addr  = (grant == ID_UNCACHED) ? m1_addr  : m0_addr;
  assign s_wdata = (grant == ID_UNCACHED) ? m1_wdata : m0_wdata;

  assign m0_addr_ok = (grant == ID_CACHED)   && accept;
  assign m1_addr_ok = (grant == ID_UNCACHED) && accept;

  assign m0_data_ok = s_data_ok && (fifo_count != '0) && (head_id == ID_CACHED);
  assign m1_data_ok = s_data_ok && (fifo_count != '0) && (head_id == ID_UNCACHED);
  assign m0_rdata   = s_rdata;
  assign m1_rdata   = s_rdata;

  // Arbiter state: lock on a stalled request, release and remember the
  // winner on acceptance. last_id starts at uncached so m0 wins the first tie.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock    <= 1'b0;
      lock_id <= ID_CACHED;
      last_id <= ID_UNCACHED;
    end else begin
      if (accept) begin
        lock    <= 1'b0;
        last_id <= grant;
      end else if (stall) begin
        lock    <= 1'b1;
        lock_id <= grant;
      end
    end
  end

  data_sram_arbiter_owner_fifo #(
    .W     (1),
    .DEPTH (OUTSTANDING),
    .CW    (CW)
  ) u_owner_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (accept),
    .push_data (grant),
    .pop       (s_data_ok && !fifo_empty),
    .head      (head_id),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_data_sram_arbiter.sv
// Bench for data_sram_arbiter: a vector table of per-cycle stimulus and
// expected handshakes, a wrap-around stress loop, and an owner scoreboard
// that predicts which master each completion belongs to.
module tb_data_sram_arbiter;
  import data_sram_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [AW-1:0] M0_ADDR  = 32'h1FC0_0000;
  localparam logic [AW-1:0] M1_ADDR  = 32'hBFAF_0010;
  localparam logic [DW-1:0] M0_WDATA = 32'h1111_2222;
  localparam logic [DW-1:0] M1_WDATA = 32'h3333_4444;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          m0_req = 1'b0, m0_wr = 1'b0;
  logic [1:0]    m0_size = SZ_WORD;
  logic [AW-1:0] m0_addr = M0_ADDR;
  logic [DW-1:0] m0_wdata = M0_WDATA;
  logic [DW-1:0] m0_rdata;
  logic          m0_addr_ok, m0_data_ok;
  logic          m1_req = 1'b0, m1_wr = 1'b1;
  logic [1:0]    m1_size = SZ_BYTE;
  logic [AW-1:0] m1_addr = M1_ADDR;
  logic [DW-1:0] m1_wdata = M1_WDATA;
  logic [DW-1:0] m1_rdata;
  logic          m1_addr_ok, m1_data_ok;
  logic          s_req, s_wr;
  logic [1:0]    s_size;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [DW-1:0] s_rdata = '0;
  logic          s_addr_ok = 1'b0, s_data_ok = 1'b0;

  int checks = 0;
  int failures = 0;
  bit owner_q[$];

  typedef struct {
    bit          rst, r0, r1, aok, dok;
    logic [31:0] rdata;
    bit          exp_sreq, chk_grant, exp_grant, acc0, acc1;
    string       name;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  data_sram_arbiter #(.OUTSTANDING(2), .AW(AW), .DW(DW)) dut (
    .clk(clk), .resetn(resetn),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_addr_ok(m0_addr_ok), .m0_data_ok(m0_data_ok),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_addr_ok(m1_addr_ok), .m1_data_ok(m1_data_ok),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok)
  );

  task automatic addVec(input bit rst, r0, r1, aok, dok, input logic [31:0] rdata,
                        input bit exp_sreq, chk_grant, exp_grant, acc0, acc1, input string name);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.r1 = r1; v.aok = aok; v.dok = dok; v.rdata = rdata;
    v.exp_sreq = exp_sreq; v.chk_grant = chk_grant; v.exp_grant = exp_grant;
    v.acc0 = acc0; v.acc1 = acc1; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit rst, r0, r1, aok, dok, input logic [31:0] rdata);
    @(negedge clk);
    resetn    = !rst;
    m0_req    = r0;
    m1_req    = r1;
    s_addr_ok = aok;
    s_data_ok = dok;
    s_rdata   = rdata;
    #1;
  endtask

  // One cycle: drive, compare handshakes and routing, update the owner scoreboard.
  task automatic runCycle(input bit rst, r0, r1, aok, dok, input logic [31:0] rdata,
                          input bit exp_sreq, chk_grant, exp_grant, acc0, acc1, input string name);
    bit exp_d0, exp_d1, owner;
    applyStimulus(rst, r0, r1, aok, dok, rdata);
    if (rst) owner_q.delete();
    checkOutput({name, " s_req"}, 32'(s_req), 32'(exp_sreq));
    checkOutput({name, " m0_addr_ok"}, 32'(m0_addr_ok), 32'(acc0));
    checkOutput({name, " m1_addr_ok"}, 32'(m1_addr_ok), 32'(acc1));
    if (chk_grant) begin
      checkOutput({name, " s_addr"}, s_addr, exp_grant ? M1_ADDR : M0_ADDR);
      checkOutput({name, " s_wdata"}, s_wdata, exp_grant ? M1_WDATA : M0_WDATA);
      checkOutput({name, " s_wr"}, 32'(s_wr), 32'(exp_grant));
    end
    exp_d0 = 1'b0;
    exp_d1 = 1'b0;
    if (dok && owner_q.size() > 0) begin
      owner  = owner_q.pop_front();
      exp_d0 = (owner == 1'b0);
      exp_d1 = (owner == 1'b1);
    end
    checkOutput({name, " m0_data_ok"}, 32'(m0_data_ok), 32'(exp_d0));
    checkOutput({name, " m1_data_ok"}, 32'(m1_data_ok), 32'(exp_d1));
    if (dok) begin
      checkOutput({name, " m0_rdata"}, m0_rdata, rdata);
      checkOutput({name, " m1_rdata"}, m1_rdata, rdata);
    end
    if (acc0) owner_q.push_back(1'b0);
    if (acc1) owner_q.push_back(1'b1);
  endtask

  // Main sequence: vector table, then wrap stress, then drain and summary.
  initial begin
    bit cur;
    bit exp_s;

    //      rst r0 r1 aok dok rdata          sreq chk g  a0 a1
    addVec(1, 1, 1, 1, 1, 32'h0,          0, 0, 0, 0, 0, "reset_hold");
    addVec(0, 1, 0, 1, 0, 32'h0,          1, 1, 0, 1, 0, "t1_m0_accept");
    addVec(0, 0, 0, 1, 0, 32'h0,          0, 0, 0, 0, 0, "t1_idle");
    addVec(0, 0, 0, 1, 1, 32'hDEADBEEF,   0, 0, 0, 0, 0, "t1_resp");
    addVec(1, 1, 1, 1, 1, 32'h0,          0, 0, 0, 0, 0, "t2_reset");
    addVec(0, 1, 1, 1, 0, 32'h0,          1, 1, 0, 1, 0, "t2_tie_m0");
    addVec(0, 0, 1, 1, 0, 32'h0,          1, 1, 1, 0, 1, "t2_m1");
    addVec(0, 0, 0, 1, 1, 32'h0000_000A,  0, 0, 0, 0, 0, "t2_respA");
    addVec(0, 0, 0, 1, 1, 32'h0000_000B,  0, 0, 0, 0, 0, "t2_respB");
    addVec(0, 1, 0, 1, 0, 32'h0,          1, 1, 0, 1, 0, "t3_acc1");
    addVec(0, 1, 0, 1, 0, 32'h0,          1, 1, 0, 1, 0, "t3_acc2");
    addVec(0, 1, 0, 1, 0, 32'h0,          0, 1, 0, 0, 0, "t3_full");
    addVec(0, 1, 0, 1, 1, 32'h0000_000C,  0, 1, 0, 0, 0, "t3_full_pop");
    addVec(0, 1, 0, 1, 0, 32'h0,          1, 1, 0, 1, 0, "t3_acc3");
    addVec(0, 0, 0, 1, 1, 32'h0000_000D,  0, 0, 0, 0, 0, "t3_respD");
    addVec(0, 0, 0, 1, 1, 32'h0000_000E,  0, 0, 0, 0, 0, "t3_respE");
    addVec(0, 1, 0, 0, 0, 32'h0,          1, 1, 0, 0, 0, "t4_stall0");
    addVec(0, 1, 1, 0, 0, 32'h0,          1, 1, 0, 0, 0, "t4_stall1");
    addVec(0, 1, 1, 0, 0, 32'h0,          1, 1, 0, 0, 0, "t4_stall2");
    addVec(0, 1, 1, 1, 0, 32'h0,          1, 1, 0, 1, 0, "t4_m0_acc");
    addVec(0, 0, 1, 1, 0, 32'h0,          1, 1, 1, 0, 1, "t4_m1_acc");
    addVec(1, 0, 0, 1, 0, 32'h0,          0, 0, 0, 0, 0, "t5_reset");
    addVec(0, 0, 0, 1, 1, 32'h0000_000F,  0, 0, 0, 0, 0, "t5_late_resp");

    foreach (vecs[i]) begin
      runCycle(vecs[i].rst, vecs[i].r0, vecs[i].r1, vecs[i].aok, vecs[i].dok, vecs[i].rdata,
               vecs[i].exp_sreq, vecs[i].chk_grant, vecs[i].exp_grant,
               vecs[i].acc0, vecs[i].acc1, vecs[i].name);
    end

    // Fill the queue, then keep completing and issuing with alternating masters.
    runCycle(0, 1, 0, 1, 0, 32'h0, 1, 1, 0, 1, 0, "t6_fill0");
    runCycle(0, 0, 1, 1, 0, 32'h0, 1, 1, 1, 0, 1, "t6_fill1");
    cur = 1'b0;
    for (int i = 0; i < 20; i++) begin
      exp_s = (owner_q.size() < 2);
      runCycle(0, cur == 1'b0, cur == 1'b1, 1, 1, 32'hC0DE_0000 + 32'(i),
               exp_s, 1, cur, exp_s && (cur == 1'b0), exp_s && (cur == 1'b1), "t6_wrap");
      if (exp_s) cur = ~cur;
    end
    for (int i = 0; i < 3; i++) begin
      runCycle(0, 0, 0, 1, 1, 32'hD0D0_0000 + 32'(i), 0, 0, 0, 0, 0, "t6_drain");
    end

    @(negedge clk);
    s_data_ok = 1'b0;
    s_addr_ok = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
